// File: rtl/top_control_batch.sv
// Batch controller: runs job_count Montgomery multiplications (LOAD -> FIOS -> STORE per job)
// with per-phase watchdog, processor abort and error reporting.
module top_control_batch #(
  parameter int JOB_W   = 8,
  parameter int TIMEOUT = 4096,
  parameter int WD_W    = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [JOB_W-1:0] job_count_i,
  input  logic             load_done_i,
  input  logic             store_done_i,
  input  logic             FIOS_last_i,
  output logic             mem_start_o,
  output logic             load_store_o,
  output logic             FIOS_start_o,
  output logic [JOB_W-1:0] job_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_LOAD_LAST = 4'd2,
    S_FIOS_INIT = 4'd3,
    S_FIOS      = 4'd4,
    S_STORE     = 4'd5,
    S_NEXT      = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic            WD_EN   = (TIMEOUT != 0);

  state_t           state_r, state_next_s;
  logic [WD_W-1:0]  wd_r, wd_next_s;
  logic [JOB_W-1:0] count_r, count_next_s;
  logic [JOB_W-1:0] job_idx_r, job_idx_next_s;
  logic [1:0]       err_code_r, err_next_s;
  logic             wd_exp_s, job_last_s, batch_start_s, in_phase_s;
  logic             mem_start_r, load_store_r, fios_start_r, busy_r, done_r, error_r;
  logic             mem_start_s, load_store_s, fios_start_s, busy_s, done_s, error_s;

  // Error code reported for a watchdog expiry in the given phase.
  function automatic logic [1:0] phase_err_code(input state_t st);
    case (st)
      S_LOAD:  phase_err_code = 2'b01;
      S_FIOS:  phase_err_code = 2'b10;
      S_STORE: phase_err_code = 2'b11;
      default: phase_err_code = 2'b00;
    endcase
  endfunction

  assign wd_exp_s      = WD_EN && (wd_r == WD_LAST);
  assign job_last_s    = (job_idx_r == (count_r - JOB_W'(1)));
  assign batch_start_s = (state_r == S_IDLE) && start_i && !abort_i;
  assign in_phase_s    = (state_r == S_LOAD) || (state_r == S_FIOS) || (state_r == S_STORE);

  // State register plus datapath and registered Moore outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r      <= S_IDLE;
      wd_r         <= {WD_W{1'b0}};
      count_r      <= {JOB_W{1'b0}};
      job_idx_r    <= {JOB_W{1'b0}};
      err_code_r   <= 2'b00;
      mem_start_r  <= 1'b0;
      load_store_r <= 1'b0;
      fios_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wd_r         <= wd_next_s;
      count_r      <= count_next_s;
      job_idx_r    <= job_idx_next_s;
      err_code_r   <= err_next_s;
      mem_start_r  <= mem_start_s;
      load_store_r <= load_store_s;
      fios_start_r <= fios_start_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  // Next-state logic; abort outranks done events and watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (batch_start_s) begin
          state_next_s = (job_count_i == {JOB_W{1'b0}}) ? S_DONE : S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort_i)          state_next_s = S_IDLE;
        else if (load_done_i) state_next_s = S_LOAD_LAST;
        else if (wd_exp_s)    state_next_s = S_ERROR;
        else                  state_next_s = S_LOAD;
      end
      S_LOAD_LAST: state_next_s = abort_i ? S_IDLE : S_FIOS_INIT;
      S_FIOS_INIT: state_next_s = abort_i ? S_IDLE : S_FIOS;
      S_FIOS: begin
        if (abort_i)          state_next_s = S_IDLE;
        else if (FIOS_last_i) state_next_s = S_STORE;
        else if (wd_exp_s)    state_next_s = S_ERROR;
        else                  state_next_s = S_FIOS;
      end
      S_STORE: begin
        if (abort_i)           state_next_s = S_IDLE;
        else if (store_done_i) state_next_s = S_NEXT;
        else if (wd_exp_s)     state_next_s = S_ERROR;
        else                   state_next_s = S_STORE;
      end
      S_NEXT: begin
        if (abort_i)         state_next_s = S_IDLE;
        else if (job_last_s) state_next_s = S_DONE;
        else                 state_next_s = S_LOAD;
      end
      S_DONE:  state_next_s = start_i ? S_DONE : S_IDLE;
      S_ERROR: state_next_s = start_i ? S_ERROR : S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath next values: watchdog restarts on every state change.
  always_comb begin
    wd_next_s      = {WD_W{1'b0}};
    count_next_s   = count_r;
    job_idx_next_s = job_idx_r;
    err_next_s     = err_code_r;
    if ((state_next_s == state_r) && in_phase_s) begin
      wd_next_s = wd_r + WD_W'(1);
    end else begin
      wd_next_s = {WD_W{1'b0}};
    end
    if (batch_start_s) begin
      count_next_s   = job_count_i;
      job_idx_next_s = {JOB_W{1'b0}};
    end else if (busy_r && abort_i) begin
      job_idx_next_s = {JOB_W{1'b0}};
    end else if ((state_r == S_NEXT) && !job_last_s) begin
      job_idx_next_s = job_idx_r + JOB_W'(1);
    end else begin
      job_idx_next_s = job_idx_r;
    end
    if ((state_next_s == S_ERROR) && (state_r != S_ERROR)) begin
      err_next_s = phase_err_code(state_r);
    end else if ((state_r == S_ERROR) && (state_next_s != S_ERROR)) begin
      err_next_s = 2'b00;
    end else if (batch_start_s) begin
      err_next_s = 2'b00;
    end else begin
      err_next_s = err_code_r;
    end
  end

  // Moore output decode of the upcoming state, registered above.
  always_comb begin
    mem_start_s  = 1'b0;
    load_store_s = 1'b0;
    fios_start_s = 1'b0;
    busy_s       = 1'b1;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_next_s)
      S_IDLE:      busy_s = 1'b0;
      S_LOAD:      mem_start_s = 1'b1;
      S_LOAD_LAST: busy_s = 1'b1;
      S_FIOS_INIT: fios_start_s = 1'b1;
      S_FIOS:      busy_s = 1'b1;
      S_STORE: begin
        mem_start_s  = 1'b1;
        load_store_s = 1'b1;
      end
      S_NEXT:      busy_s = 1'b1;
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      S_ERROR: begin
        busy_s  = 1'b0;
        error_s = 1'b1;
      end
      default:     busy_s = 1'b0;
    endcase
  end

  assign mem_start_o  = mem_start_r;
  assign load_store_o = load_store_r;
  assign FIOS_start_o = fios_start_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign error_o      = error_r;
  assign job_idx_o    = job_idx_r;
  assign err_code_o   = err_code_r;

endmodule

// File: tb/tb_top_control_batch.sv
// Directed bench for top_control_batch: default-timeout instance for the batch flow,
// TIMEOUT=16 instance for watchdog boundaries; both share the same stimulus.
module tb_top_control_batch;

  logic       clock_i = 1'b0;
  logic       reset_i, start_i, abort_i, load_done_i, store_done_i, FIOS_last_i;
  logic [7:0] job_count_i;

  logic       mem_start, load_store, fios_start, busy, done, error;
  logic [7:0] job_idx;
  logic [1:0] err_code;
  logic       w_mem_start, w_load_store, w_fios_start, w_busy, w_done, w_error;
  logic [7:0] w_job_idx;
  logic [1:0] w_err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;
  int fios_cnt = 0;
  int mem_snap, fios_snap;

  top_control_batch dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .job_count_i(job_count_i), .load_done_i(load_done_i), .store_done_i(store_done_i),
    .FIOS_last_i(FIOS_last_i), .mem_start_o(mem_start), .load_store_o(load_store),
    .FIOS_start_o(fios_start), .job_idx_o(job_idx), .busy_o(busy), .done_o(done),
    .error_o(error), .err_code_o(err_code)
  );

  top_control_batch #(.JOB_W(8), .TIMEOUT(16), .WD_W(16)) dut_wd (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .job_count_i(job_count_i), .load_done_i(load_done_i), .store_done_i(store_done_i),
    .FIOS_last_i(FIOS_last_i), .mem_start_o(w_mem_start), .load_store_o(w_load_store),
    .FIOS_start_o(w_fios_start), .job_idx_o(w_job_idx), .busy_o(w_busy), .done_o(w_done),
    .error_o(w_error), .err_code_o(w_err_code)
  );

  always #5 clock_i = ~clock_i;

  // Activity counters for the default instance, sampled mid-cycle.
  always @(negedge clock_i) begin
    if (mem_start)  mem_cnt  <= mem_cnt + 1;
    if (fios_start) fios_cnt <= fios_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    load_done_i = 1'b0; store_done_i = 1'b0; FIOS_last_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
  endtask

  // Drive one job from its first LOAD cycle to the cycle after store_done_i.
  task automatic run_job(input int ld, input int fl, input int st, input logic abort_st,
                         input logic [7:0] idx, input logic chk);
    repeat (ld) step();
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    if (chk) begin
      check_eq("load_last_mem", mem_start, 1'b0);
      check_eq("load_last_busy", busy, 1'b1);
    end
    step();
    if (chk) check_eq("fios_init_pulse", fios_start, 1'b1);
    step();
    if (chk) check_eq("fios_pulse_end", fios_start, 1'b0);
    repeat (fl) step();
    FIOS_last_i = 1'b1; step(); FIOS_last_i = 1'b0;
    if (chk) begin
      check_eq("store_mem", mem_start, 1'b1);
      check_eq("store_dir", load_store, 1'b1);
      check_eq("store_idx", job_idx, idx);
    end
    repeat (st) step();
    store_done_i = 1'b1; abort_i = abort_st; step();
    store_done_i = 1'b0; abort_i = 1'b0;
  endtask

  initial begin
    job_count_i = 8'd0;
    do_reset();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_mem", mem_start, 1'b0);
    check_eq("rst_idx", job_idx, 8'd0);
    check_eq("rst_err_code", err_code, 2'b00);

    // Three-job batch with the nominal handshake delays.
    fios_snap = fios_cnt;
    job_count_i = 8'd3; start_i = 1'b1; step(); start_i = 1'b0;
    check_eq("b1_load_mem", mem_start, 1'b1);
    check_eq("b1_load_dir", load_store, 1'b0);
    for (int j = 0; j < 3; j++) begin
      check_eq("b1_job_idx", job_idx, j);
      run_job(4, 19, 4, 1'b0, 8'(j), 1'b1);
      check_eq("b1_next_busy", busy, 1'b1);
      check_eq("b1_next_mem", mem_start, 1'b0);
      check_eq("b1_next_done", done, 1'b0);
      step();
    end
    check_eq("b1_done", done, 1'b1);
    check_eq("b1_busy_fall", busy, 1'b0);
    check_eq("b1_final_idx", job_idx, 8'd2);
    check_eq("b1_fios_pulses", fios_cnt - fios_snap, 3);
    step();
    check_eq("b1_idle_done", done, 1'b0);

    // Zero-job batch, start held in DONE, then re-arm.
    do_reset();
    mem_snap = mem_cnt; fios_snap = fios_cnt;
    job_count_i = 8'd0; start_i = 1'b1; step();
    check_eq("z_done", done, 1'b1);
    check_eq("z_busy", busy, 1'b0);
    repeat (10) step();
    check_eq("z_done_held", done, 1'b1);
    start_i = 1'b0; step();
    check_eq("z_idle", done, 1'b0);
    check_eq("z_no_mem", mem_cnt - mem_snap, 0);
    check_eq("z_no_fios", fios_cnt - fios_snap, 0);
    job_count_i = 8'd2; start_i = 1'b1; step(); start_i = 1'b0;
    check_eq("rearm_busy", busy, 1'b1);
    check_eq("rearm_idx", job_idx, 8'd0);
    check_eq("rearm_mem", mem_start, 1'b1);
    step(); step();
    reset_i = 1'b1; step(); reset_i = 1'b0;
    check_eq("midreset_busy", busy, 1'b0);
    check_eq("midreset_mem", mem_start, 1'b0);

    // FIOS watchdog in job 1 on the TIMEOUT=16 instance.
    do_reset();
    job_count_i = 8'd2; start_i = 1'b1; step(); start_i = 1'b0;
    run_job(0, 0, 0, 1'b0, 8'd0, 1'b0);
    step();
    check_eq("wd_job1_idx", w_job_idx, 8'd1);
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    step(); step();
    repeat (15) step();
    check_eq("wd_fios_no_err_yet", w_error, 1'b0);
    check_eq("wd_fios_busy", w_busy, 1'b1);
    step();
    check_eq("wd_fios_error", w_error, 1'b1);
    check_eq("wd_fios_code", w_err_code, 2'b10);
    check_eq("wd_fios_idx_hold", w_job_idx, 8'd1);
    check_eq("wd_fios_busy_low", w_busy, 1'b0);
    check_eq("wd_default_inst_ok", error, 1'b0);
    step();
    check_eq("wd_err_exit", w_error, 1'b0);
    check_eq("wd_code_clear", w_err_code, 2'b00);

    // load_done_i in the expiry cycle wins over the watchdog.
    do_reset();
    job_count_i = 8'd1; start_i = 1'b1; step(); start_i = 1'b0;
    repeat (15) step();
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    check_eq("wd_edge_no_err", w_error, 1'b0);
    check_eq("wd_edge_busy", w_busy, 1'b1);
    check_eq("wd_edge_load_last", w_mem_start, 1'b0);

    // Load timeout without load_done_i.
    do_reset();
    job_count_i = 8'd1; start_i = 1'b1; step(); start_i = 1'b0;
    repeat (15) step();
    check_eq("wd_load_pending", w_error, 1'b0);
    step();
    check_eq("wd_load_error", w_error, 1'b1);
    check_eq("wd_load_code", w_err_code, 2'b01);

    // Abort together with store_done_i in job 1 of 4.
    do_reset();
    job_count_i = 8'd4; start_i = 1'b1; step(); start_i = 1'b0;
    run_job(0, 0, 0, 1'b0, 8'd0, 1'b0);
    step();
    check_eq("ab_job1_idx", job_idx, 8'd1);
    run_job(1, 2, 1, 1'b1, 8'd1, 1'b1);
    check_eq("ab_idle_busy", busy, 1'b0);
    check_eq("ab_idle_done", done, 1'b0);
    check_eq("ab_idle_mem", mem_start, 1'b0);
    check_eq("ab_idle_idx", job_idx, 8'd0);
    step();
    check_eq("ab_stays_idle", busy, 1'b0);
    check_eq("ab_no_done", done, 1'b0);
    abort_i = 1'b1; start_i = 1'b1; step();
    check_eq("ab_start_blocked", busy, 1'b0);
    abort_i = 1'b0; step(); start_i = 1'b0;
    check_eq("ab_restart_busy", busy, 1'b1);
    check_eq("ab_restart_idx", job_idx, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
